servo_pwm_multi: RTL and testbench
==================================

# servo_pwm_multi

Multi-channel hobby-servo PWM generator, the parametrised successor to the single-channel servo top. It accepts per-channel angle commands over a valid/ready interface, slew-limits each channel toward its target once per frame, and produces one PWM pulse per frame per channel with width linear in angle. Per-channel over-current samples latch a fault that forces that channel's output low until it is explicitly cleared. It sits between the control/host logic and the servo output pins.

## Interface
- N_CH, 4, number of servo channels
- PERIOD_CYC, 1000000, frame length in clk cycles (20 ms at 50 MHz)
- MIN_CYC, 50000, pulse width at 0°
- MAX_CYC, 100000, nominal pulse width at 180°
- INIT_ANGLE, 90, reset angle and target for all channels
- SLEW_STEP, 0, max degrees moved per frame; 0 = jump directly to target
- CUR_W, 12, current sample width
- OC_COUNT, 3, consecutive over-limit samples that trip a fault
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  global output enable
- cmd_valid  in  1  angle command valid
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_ch  in  $clog2(N_CH)  target channel
- cmd_angle  in  8  angle in degrees, 0..255; values >180 clamp to 180
- cur_valid  in  1  current sample valid
- cur_ch  in  $clog2(N_CH)  channel of sample
- cur_value  in  CUR_W  measured current, unsigned
- cur_limit  in  CUR_W  over-current threshold, shared by all channels
- fault_clr  in  N_CH  per-channel fault clear pulse
- pwm_out  out  N_CH  servo pulse outputs
- fault  out  N_CH  latched over-current fault
- frame_tick  out  1  one-cycle pulse at each frame start

## Operation
- CYC_PER_DEG = (MAX_CYC-MIN_CYC)/180, integer-truncated; width = MIN_CYC + angle*CYC_PER_DEG (defaults: 90° -> 74930).
- Frame counter cnt counts 0..PERIOD_CYC-1 and wraps; counting only while en=1. While en=0, cnt is held at PERIOD_CYC-1, pwm_out=0, frame_tick=0.
- Command: cmd_ready=1 whenever not in reset. On accept, target[cmd_ch] <= min(cmd_angle,180). Same-channel back-to-back commands: last one wins.
- Frame boundary (cycle where cnt==PERIOD_CYC-1 and en=1): per channel, pos moves toward target by min(|target-pos|, SLEW_STEP), or to target if SLEW_STEP=0; width_q loaded from the new pos. A command accepted in the boundary cycle is not seen until the next boundary.
- pwm_out[i] is registered: (cnt < width_q[i]) && en && !fault[i]. High for exactly width_q[i] cycles per frame.
- Over-current: on cur_valid, if cur_value > cur_limit then oc_cnt[cur_ch]++ (saturating), else oc_cnt[cur_ch] <= 0. When it reaches OC_COUNT, fault[cur_ch] sets. fault is sticky; fault_clr[i] clears fault[i] and oc_cnt[i]. If a set and a clear hit the same channel in the same cycle, set wins.
- A faulted channel keeps slewing pos/width; only its output is gated.

## Timing
- Reset values: pwm_out=0, fault=0, frame_tick=0, cmd_ready=0 during reset, cnt=PERIOD_CYC-1, pos=target=INIT_ANGLE, width_q=MIN_CYC+INIT_ANGLE*CYC_PER_DEG, oc_cnt=0.
- First cycle after reset release with en=1: boundary update; frame_tick and rising pwm_out appear one cycle later, aligned with each other.
- Command-to-output latency: the next frame boundary after acceptance (1 frame worst case + 1 cycle).
- Fault set: pwm_out[i] low on the cycle after the tripping sample's edge, even mid-pulse. Fault clear: output resumes at the next cycle where cnt < width_q, mid-frame allowed.
- en falling mid-frame: pwm_out low the next cycle; partial pulse is not completed.
- rst mid-frame: all state returns to reset values immediately (asynchronous).
- Arithmetic: width_q needs $clog2(PERIOD_CYC) bits; angle*CYC_PER_DEG is computed at full width with no overflow.

## Test plan
Overrides: PERIOD_CYC=1000, MIN_CYC=100, MAX_CYC=280 (CYC_PER_DEG=1), OC_COUNT=3.
- Reset then en=1, no commands -> every channel pulses 190 cycles per 1000-cycle frame; frame_tick every 1000 cycles; fault=0.
- Command ch2=0, ch3=200 -> from the next frame, ch2 is 100 cycles and ch3 is 280 cycles (clamped); ch0/ch1 stay 190.
- SLEW_STEP=10, ch0 from 90 to 130 -> widths 200, 210, 220, 230 across four successive frames, then steady at 230.
- ch1 samples 600,600,600 with limit 500 -> fault[1] after the third sample; pwm_out[1] drops next cycle mid-pulse. A sample pattern of 600,400,600 does not trip.
- fault_clr[1] in the same cycle as a tripping sample -> fault stays set; a later clear alone -> output resumes in the next pulse window.
- Drop en mid-pulse, then rst mid-frame -> outputs go low immediately; after release, the frame restarts with 190-cycle pulses.

Source files
------------

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel hobby-servo PWM with per-frame slew limiting and latched over-current cutoff.
// Latency: an accepted angle reaches pwm_out at the next frame boundary (worst case 1 frame + 1 cycle).
// Backpressure: none; cmd_ready is high whenever rst is low, and the last command per channel wins.
// Ports: clk/rst (async active-high); en gates counting and outputs; cmd_* loads a channel target angle;
//        cur_* feeds per-channel current samples compared to cur_limit; fault_clr clears latched faults;
//        pwm_out/fault per channel; frame_tick pulses once per frame start.
module servo_pwm_multi #(
  parameter int N_CH       = 4,
  parameter int PERIOD_CYC = 1000000,
  parameter int MIN_CYC    = 50000,
  parameter int MAX_CYC    = 100000,
  parameter int INIT_ANGLE = 90,
  parameter int SLEW_STEP  = 0,
  parameter int CUR_W      = 12,
  parameter int OC_COUNT   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [$clog2(N_CH)-1:0] cmd_ch,
  input  logic [7:0]              cmd_angle,
  input  logic                    cur_valid,
  input  logic [$clog2(N_CH)-1:0] cur_ch,
  input  logic [CUR_W-1:0]        cur_value,
  input  logic [CUR_W-1:0]        cur_limit,
  input  logic [N_CH-1:0]         fault_clr,
  output logic [N_CH-1:0]         pwm_out,
  output logic [N_CH-1:0]         fault,
  output logic                    frame_tick
);

  localparam int CHW = $clog2(N_CH);
  localparam int CW  = $clog2(PERIOD_CYC);
  localparam int CPD = (MAX_CYC - MIN_CYC) / 180;
  localparam int OCW = $clog2(OC_COUNT + 1);
  localparam logic [CW-1:0]  CNT_LAST   = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0]  WIDTH_INIT = CW'(MIN_CYC + INIT_ANGLE * CPD);
  localparam logic [7:0]     ANGLE_INIT = 8'(INIT_ANGLE);
  localparam logic [7:0]     STEP       = 8'((SLEW_STEP > 255) ? 255 : SLEW_STEP);
  localparam logic [OCW-1:0] OC_TRIP    = OCW'(OC_COUNT);

  logic [CW-1:0]  cnt, cnt_nxt;
  logic [7:0]     pos     [N_CH];
  logic [7:0]     pos_nxt [N_CH];
  logic [7:0]     target  [N_CH];
  logic [CW-1:0]  width_q   [N_CH];
  logic [CW-1:0]  width_nxt [N_CH];
  logic [OCW-1:0] oc_cnt [N_CH];
  logic [OCW-1:0] oc_nxt [N_CH];
  logic [N_CH-1:0] fault_nxt, pwm_nxt;
  logic [7:0]     cmd_clamped;
  logic [7:0]     diff;
  logic           boundary;

  assign cmd_ready   = ~rst;
  assign boundary    = en && (cnt == CNT_LAST);
  assign cmd_clamped = (cmd_angle > 8'd180) ? 8'd180 : cmd_angle;

  // While disabled the counter parks on the last cycle so re-enabling starts a fresh frame at once.
  always_comb begin
    cnt_nxt = CNT_LAST;
    if (en) cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
  end

  // Slew pos toward target once per frame; faulted channels keep tracking so they resume at the right angle.
  always_comb begin
    diff = '0;
    for (int i = 0; i < N_CH; i++) begin
      pos_nxt[i]   = pos[i];
      width_nxt[i] = width_q[i];
      if (boundary) begin
        diff = (target[i] > pos[i]) ? (target[i] - pos[i]) : (pos[i] - target[i]);
        if (SLEW_STEP == 0 || diff <= STEP) pos_nxt[i] = target[i];
        else if (target[i] > pos[i])        pos_nxt[i] = pos[i] + STEP;
        else                                pos_nxt[i] = pos[i] - STEP;
        width_nxt[i] = CW'(MIN_CYC + int'(pos_nxt[i]) * CPD);
      end
    end
  end

  // The sample update works from the pre-clear count, so a trip coinciding with a clear still latches.
  always_comb begin
    fault_nxt = fault & ~fault_clr;
    for (int i = 0; i < N_CH; i++) begin
      oc_nxt[i] = fault_clr[i] ? '0 : oc_cnt[i];
      if (cur_valid && cur_ch == CHW'(i)) begin
        if (cur_value > cur_limit) begin
          oc_nxt[i] = (oc_cnt[i] >= OC_TRIP) ? OC_TRIP : oc_cnt[i] + OCW'(1);
          if (oc_nxt[i] == OC_TRIP) fault_nxt[i] = 1'b1;
        end else begin
          oc_nxt[i] = '0;
        end
      end
    end
  end

  // Output is registered from next-state values so the pulse rises together with frame_tick
  // and a trip or en drop takes effect on the very next cycle.
  always_comb begin
    for (int i = 0; i < N_CH; i++)
      pwm_nxt[i] = en && (cnt_nxt < width_nxt[i]) && !fault_nxt[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= CNT_LAST;
      frame_tick <= 1'b0;
      pwm_out    <= '0;
      fault      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        pos[i]     <= ANGLE_INIT;
        target[i]  <= ANGLE_INIT;
        width_q[i] <= WIDTH_INIT;
        oc_cnt[i]  <= '0;
      end
    end else begin
      cnt        <= cnt_nxt;
      frame_tick <= boundary;
      pwm_out    <= pwm_nxt;
      fault      <= fault_nxt;
      for (int i = 0; i < N_CH; i++) begin
        pos[i]     <= pos_nxt[i];
        width_q[i] <= width_nxt[i];
        oc_cnt[i]  <= oc_nxt[i];
        if (cmd_valid && cmd_ch == CHW'(i)) target[i] <= cmd_clamped;
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: checks two servo_pwm_multi instances (no slew / slew 10) against a frame-level model.
// Latency: expectations are queued one cycle ahead and consumed by an independent per-cycle monitor.
// Backpressure: none; stimulus is driven every cycle on the falling edge.
module tb_servo_pwm_multi;
  localparam int N_CH = 4, PERIOD = 1000, MINC = 100, MAXC = 280, OCN = 3, CW = 12, SLEW_B = 10;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic cmd_valid = 1'b0, cur_valid = 1'b0;
  logic [1:0] cmd_ch = '0, cur_ch = '0;
  logic [7:0] cmd_angle = '0;
  logic [CW-1:0] cur_value = '0, cur_limit = 12'd500;
  logic [3:0] fault_clr = '0;
  logic ready_a, ready_b, tick_a, tick_b;
  logic [3:0] pwm_a, pwm_b, fault_a, fault_b;

  typedef struct packed {
    logic [3:0] pwm_a, pwm_b, fault_a, fault_b;
    logic tick_a, tick_b, ready_a, ready_b;
  } obs_t;

  obs_t exp_q[$];
  int checks = 0, failures = 0;
  bit mon_on = 1'b0;

  // model state: frame position, shared targets/faults, per-instance positions and widths
  int m_cnt;
  int m_tgt[4];
  int m_oc[4];
  int m_pos[2][4];
  int m_wid[2][4];
  logic [3:0] m_fault;
  int hi_a[4], hi_b[4], ticks;

  always #5 clk = ~clk;

  servo_pwm_multi #(.N_CH(N_CH), .PERIOD_CYC(PERIOD), .MIN_CYC(MINC), .MAX_CYC(MAXC), .INIT_ANGLE(90),
                    .SLEW_STEP(0), .CUR_W(CW), .OC_COUNT(OCN)) dut_a (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(ready_a), .cmd_ch(cmd_ch),
    .cmd_angle(cmd_angle), .cur_valid(cur_valid), .cur_ch(cur_ch), .cur_value(cur_value),
    .cur_limit(cur_limit), .fault_clr(fault_clr), .pwm_out(pwm_a), .fault(fault_a), .frame_tick(tick_a));

  servo_pwm_multi #(.N_CH(N_CH), .PERIOD_CYC(PERIOD), .MIN_CYC(MINC), .MAX_CYC(MAXC), .INIT_ANGLE(90),
                    .SLEW_STEP(SLEW_B), .CUR_W(CW), .OC_COUNT(OCN)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(ready_b), .cmd_ch(cmd_ch),
    .cmd_angle(cmd_angle), .cur_valid(cur_valid), .cur_ch(cur_ch), .cur_value(cur_value),
    .cur_limit(cur_limit), .fault_clr(fault_clr), .pwm_out(pwm_b), .fault(fault_b), .frame_tick(tick_b));

  function automatic int width_of(input int ang);
    return MINC + ang * ((MAXC - MINC) / 180);
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  // Advance the model across the coming rising edge using the inputs currently driven.
  task automatic model_step();
    obs_t e;
    int st, d_ang, ch, old_oc;
    bit bnd;
    e = '0;
    if (rst) begin
      m_cnt = PERIOD - 1;
      m_fault = '0;
      for (int i = 0; i < 4; i++) begin
        m_tgt[i] = 90;
        m_oc[i] = 0;
        for (int d = 0; d < 2; d++) begin
          m_pos[d][i] = 90;
          m_wid[d][i] = width_of(90);
        end
      end
    end else begin
      bnd = en && (m_cnt == PERIOD - 1);
      if (bnd) begin
        for (int d = 0; d < 2; d++) begin
          st = (d == 0) ? 0 : SLEW_B;
          for (int i = 0; i < 4; i++) begin
            d_ang = m_tgt[i] - m_pos[d][i];
            if (st == 0 || (d_ang <= st && d_ang >= -st)) m_pos[d][i] = m_tgt[i];
            else if (d_ang > 0) m_pos[d][i] += st;
            else m_pos[d][i] -= st;
            m_wid[d][i] = width_of(m_pos[d][i]);
          end
        end
      end
      if (cmd_valid) m_tgt[cmd_ch] = (cmd_angle > 180) ? 180 : int'(cmd_angle);
      m_cnt = en ? (m_cnt + 1) % PERIOD : PERIOD - 1;
      ch = int'(cur_ch);
      old_oc = m_oc[ch];
      for (int i = 0; i < 4; i++)
        if (fault_clr[i]) begin
          m_fault[i] = 1'b0;
          m_oc[i] = 0;
        end
      if (cur_valid) begin
        if (cur_value > cur_limit) begin
          m_oc[ch] = (old_oc + 1 > OCN) ? OCN : old_oc + 1;
          if (m_oc[ch] == OCN) m_fault[ch] = 1'b1;
        end else begin
          m_oc[ch] = 0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        e.pwm_a[i] = en && (m_cnt < m_wid[0][i]) && !m_fault[i];
        e.pwm_b[i] = en && (m_cnt < m_wid[1][i]) && !m_fault[i];
      end
      e.fault_a = m_fault;
      e.fault_b = m_fault;
      e.tick_a = bnd;
      e.tick_b = bnd;
      e.ready_a = 1'b1;
      e.ready_b = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick_cycle();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick_cycle();
  endtask

  task automatic send_cmd(input int ch, input int ang);
    cmd_valid = 1'b1; cmd_ch = 2'(ch); cmd_angle = 8'(ang);
    tick_cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic send_cur(input int ch, input int val, input logic [3:0] clr);
    cur_valid = 1'b1; cur_ch = 2'(ch); cur_value = CW'(val); fault_clr = clr;
    tick_cycle();
    cur_valid = 1'b0; fault_clr = '0;
  endtask

  // Stop just before a frame boundary so a following measurement window starts at cycle 0 of a frame.
  task automatic sync_frame();
    for (int k = 0; k < PERIOD + 2 && m_cnt != PERIOD - 1; k++) tick_cycle();
  endtask

  task automatic measure_frame(input bit with_cmd, input int ch, input int ang);
    ticks = 0;
    for (int i = 0; i < 4; i++) begin hi_a[i] = 0; hi_b[i] = 0; end
    for (int k = 0; k < PERIOD; k++) begin
      if (k == 0 && with_cmd) begin
        cmd_valid = 1'b1; cmd_ch = 2'(ch); cmd_angle = 8'(ang);
      end
      tick_cycle();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
        hi_a[i] += int'(pwm_a[i]);
        hi_b[i] += int'(pwm_b[i]);
      end
      ticks += int'(tick_a);
    end
  endtask

  task automatic chk_frame(input string tag, input int a0, input int a1, input int a2, input int a3, input int b0);
    chk({tag, "_a0"}, hi_a[0], a0);
    chk({tag, "_a1"}, hi_a[1], a1);
    chk({tag, "_a2"}, hi_a[2], a2);
    chk({tag, "_a3"}, hi_a[3], a3);
    chk({tag, "_b0"}, hi_b[0], b0);
    chk({tag, "_ticks"}, ticks, 1);
  endtask

  // Monitor: one sample per cycle, compared with the oldest queued expectation.
  initial begin
    obs_t act, e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        act = '{pwm_a: pwm_a, pwm_b: pwm_b, fault_a: fault_a, fault_b: fault_b,
                tick_a: tick_a, tick_b: tick_b, ready_a: ready_a, ready_b: ready_b};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty got=%05h want=entry t=%0t", act, $time);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL cycle_outputs got=%05h want=%05h t=%0t", act, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    mon_on = 1'b1;
    run(3);
    chk("rst_pwm_a", int'(pwm_a), 0);
    chk("rst_fault_a", int'(fault_a), 0);
    chk("rst_tick_a", int'(tick_a), 0);
    chk("rst_ready_a", int'(ready_a), 0);
    rst = 1'b0;
    run(3);
    chk("idle_pwm_b", int'(pwm_b), 0);

    // default angle everywhere
    en = 1'b1;
    sync_frame();
    measure_frame(1'b0, 0, 0);
    chk_frame("base", 190, 190, 190, 190, 190);

    // first command lands in a boundary cycle and still takes effect one frame later
    send_cmd(2, 0);
    send_cmd(3, 200);
    send_cmd(0, 130);
    sync_frame();
    measure_frame(1'b0, 0, 0);
    chk_frame("cmd_f1", 230, 190, 100, 280, 200);
    measure_frame(1'b0, 0, 0);
    chk_frame("slew_f2", 230, 190, 100, 280, 210);
    measure_frame(1'b0, 0, 0);
    chk_frame("slew_f3", 230, 190, 100, 280, 220);
    measure_frame(1'b0, 0, 0);
    chk_frame("slew_f4", 230, 190, 100, 280, 230);
    measure_frame(1'b0, 0, 0);
    chk_frame("slew_hold", 230, 190, 100, 280, 230);

    // command accepted in the boundary cycle is deferred a full frame
    measure_frame(1'b1, 1, 0);
    chk_frame("bnd_cmd_old", 230, 190, 100, 280, 230);
    measure_frame(1'b0, 0, 0);
    chk_frame("bnd_cmd_new", 230, 100, 100, 280, 230);

    // over-current on ch1 mid-pulse
    run(41);
    chk("oc_pre_pwm1", int'(pwm_a[1]), 1);
    send_cur(1, 600, 4'b0000);
    send_cur(1, 400, 4'b0000);
    send_cur(1, 600, 4'b0000);
    chk("oc_no_trip", int'(fault_a[1]), 0);
    send_cur(1, 400, 4'b0000);
    send_cur(1, 600, 4'b0000);
    send_cur(1, 600, 4'b0000);
    chk("oc_two", int'(fault_a[1]), 0);
    send_cur(1, 600, 4'b0000);
    chk("oc_trip", int'(fault_a[1]), 1);
    chk("oc_pwm1_low", int'(pwm_a[1]), 0);
    chk("oc_pwm1b_low", int'(pwm_b[1]), 0);
    chk("oc_pwm0_keep", int'(pwm_a[0]), 1);
    send_cur(1, 600, 4'b0010);
    chk("oc_set_wins", int'(fault_a[1]), 1);
    run(500);
    fault_clr = 4'b0010;
    tick_cycle();
    fault_clr = '0;
    chk("oc_cleared", int'(fault_a[1]), 0);
    chk("oc_clr_outside", int'(pwm_a[1]), 0);
    sync_frame();
    measure_frame(1'b0, 0, 0);
    chk_frame("oc_resume", 230, 100, 100, 280, 230);

    // en drop mid-pulse cuts the pulse immediately
    run(51);
    chk("en_pre_pwm0", int'(pwm_a[0]), 1);
    en = 1'b0;
    tick_cycle();
    chk("en_off_pwm_a", int'(pwm_a), 0);
    chk("en_off_pwm_b", int'(pwm_b), 0);
    run(20);

    // randomized traffic against the model
    en = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        cmd_valid = 1'b1; cmd_ch = 2'($urandom_range(0, 3)); cmd_angle = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) begin
        cur_valid = 1'b1; cur_ch = 2'($urandom_range(0, 3)); cur_value = CW'($urandom_range(300, 700));
      end
      if ($urandom_range(0, 499) == 0) fault_clr = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 2999) == 0) en = ~en;
      tick_cycle();
      cmd_valid = 1'b0; cur_valid = 1'b0; fault_clr = '0;
    end
    en = 1'b1;

    // asynchronous reset mid-frame with a pulse high and a fault latched
    fault_clr = 4'hF;
    tick_cycle();
    fault_clr = '0;
    sync_frame();
    tick_cycle();
    for (int i = 0; i < 4; i++) send_cmd(i, 180);
    sync_frame();
    run(151);
    chk("rst_pre_pwm0", int'(pwm_a[0]), 1);
    send_cur(2, 700, 4'b0000);
    send_cur(2, 700, 4'b0000);
    send_cur(2, 700, 4'b0000);
    chk("rst_pre_fault2", int'(fault_a[2]), 1);
    rst = 1'b1;
    #1;
    chk("arst_pwm_a", int'(pwm_a), 0);
    chk("arst_pwm_b", int'(pwm_b), 0);
    chk("arst_fault", int'(fault_a), 0);
    chk("arst_ready", int'(ready_b), 0);
    run(3);
    rst = 1'b0;
    sync_frame();
    measure_frame(1'b0, 0, 0);
    chk_frame("post_rst", 190, 190, 190, 190, 190);

    chk("scoreboard_drained", exp_q.size(), 0);
    mon_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
